// File: rtl/ras_stack.sv
// Return-address stack: circular array with top-of-stack pointer, occupancy count,
// write-first registered top. Optional checkpoint/restore enabled by RAS_CKPT_EN.
module ras_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFS   = 0,
    parameter int unsigned INCR  = 0,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_addr_i,
    input  logic             pop_i,
    input  logic             restore_i,
    input  logic [PW+CW-1:0] restore_ckpt_i,
    output logic [PW+CW-1:0] ckpt_o,
    output logic [WIDTH-1:0] top_o,
    output logic             top_valid_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    typedef logic [WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[PW'(i)] = WIDTH'(OFS + i * INCR);
        end
        return m;
    endfunction

    // Power-up contents only; neither reset nor restore ever clears the array.
    mem_t mem = init_mem();

    logic [PW-1:0] ptr_q, ptr_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic          chg;
    logic          ovf_n, unf_n;
    logic          full_c;

    assign full_c  = (cnt_q == CW'(DEPTH));
    assign full_o  = full_c;
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

`ifdef RAS_CKPT_EN
    assign ckpt_o = {ptr_q, cnt_q};
`else
    assign ckpt_o = '0;
    wire unused_restore = ^{restore_i, restore_ckpt_i};
`endif

    // Next pointer/count and the single array write for this cycle.
    always_comb begin
        ptr_n  = ptr_q;
        cnt_n  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        chg    = 1'b0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
`ifdef RAS_CKPT_EN
        if (restore_i) begin
            {ptr_n, cnt_n} = restore_ckpt_i;
            chg            = 1'b1;
        end else
`endif
        if (push_i && pop_i) begin
            wr_en = 1'b1;
            chg   = 1'b1;
        end else if (push_i) begin
            ptr_n  = ptr_q + PW'(1);
            wr_idx = ptr_q + PW'(1);
            wr_en  = 1'b1;
            chg    = 1'b1;
            if (full_c) begin
                ovf_n = 1'b1;
            end else begin
                cnt_n = cnt_q + CW'(1);
            end
        end else if (pop_i) begin
            if (cnt_q == '0) begin
                unf_n = 1'b1;
            end else begin
                ptr_n = ptr_q - PW'(1);
                cnt_n = cnt_q - CW'(1);
                chg   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= push_addr_i;
        end
    end

    // Any write lands on the new top, so the pushed value bypasses the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            top_o       <= '0;
            top_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            ptr_q       <= ptr_n;
            cnt_q       <= cnt_n;
            top_valid_o <= (cnt_n != '0);
            overflow_o  <= ovf_n;
            underflow_o <= unf_n;
            if (chg) begin
                top_o <= wr_en ? push_addr_i : mem[ptr_n];
            end
        end
    end

endmodule
